// File: rtl/ccp_evict_wb_buffer.sv
// Eviction writeback buffer: in-order FIFO of victim lines with a line match port.
// Optional zero-latency bypass when CCP_EVICT_WB_BYPASS_EN is defined.
module ccp_evict_wb_buffer #(
  parameter int ADDRESS_W           = 40,
  parameter int CACHE_LINE_OFFSET_W = 6,
  parameter int DEPTH               = 4,
  parameter int PTR_W               = $clog2(DEPTH),
  parameter int CNT_W               = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 evict_valid,
  output logic                 evict_ready,
  input  logic [ADDRESS_W-1:0] evict_address,
  input  logic                 evict_dirty,
  output logic                 wb_req_valid,
  input  logic                 wb_req_ready,
  output logic [ADDRESS_W-1:0] wb_req_addr,
  output logic                 wb_req_dirty,
  input  logic [ADDRESS_W-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty
);

  localparam int TAG_W = ADDRESS_W - CACHE_LINE_OFFSET_W;
  localparam logic [ADDRESS_W-1:0] LINE_MASK =
    {{TAG_W{1'b1}}, {CACHE_LINE_OFFSET_W{1'b0}}};

  logic [ADDRESS_W-1:0] addr_q [DEPTH];
  logic                 dirty_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [CNT_W-1:0]     cnt;
  logic                 push;
  logic                 pop;
  logic                 head_valid;

  function automatic logic line_eq(
    input logic [ADDRESS_W-1:0] a,
    input logic [ADDRESS_W-1:0] b
  );
    return ((a ^ b) & LINE_MASK) == '0;
  endfunction

  assign full        = cnt == CNT_W'(DEPTH);
  assign empty       = cnt == '0;
  assign occupancy   = cnt;
  assign evict_ready = !full;
  assign head_valid  = !empty;

`ifdef CCP_EVICT_WB_BYPASS_EN
  logic byp;
  assign byp          = empty & evict_valid;
  assign wb_req_valid = head_valid | byp;
  assign pop          = head_valid & wb_req_ready;
  assign push         = evict_valid & evict_ready
                      & !(byp & wb_req_ready);

  // Head entry, or the live eviction when bypassing an empty buffer
  always_comb begin
    wb_req_addr  = '0;
    wb_req_dirty = 1'b0;
    if (byp) begin
      wb_req_addr  = evict_address;
      wb_req_dirty = evict_dirty;
    end else if (head_valid) begin
      wb_req_addr  = addr_q[rptr];
      wb_req_dirty = dirty_q[rptr];
    end
  end

  // Line match over stored entries plus the bypassed eviction
  always_comb begin
    lookup_hit = byp & line_eq(evict_address, lookup_addr);
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && line_eq(addr_q[i], lookup_addr))
        lookup_hit = 1'b1;
  end
`else
  assign wb_req_valid = head_valid;
  assign pop          = head_valid & wb_req_ready;
  assign push         = evict_valid & evict_ready;

  // Head entry drives the request; zeros when nothing is pending
  always_comb begin
    wb_req_addr  = '0;
    wb_req_dirty = 1'b0;
    if (head_valid) begin
      wb_req_addr  = addr_q[rptr];
      wb_req_dirty = dirty_q[rptr];
    end
  end

  // Line match over stored entries only
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && line_eq(addr_q[i], lookup_addr))
        lookup_hit = 1'b1;
  end
`endif

  // Entry storage, valid bits, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      if (pop) begin
        vld_q[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      if (push) begin
        addr_q[wptr]  <= evict_address;
        dirty_q[wptr] <= evict_dirty;
        vld_q[wptr]   <= 1'b1;
        wptr          <= wptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
